// File: rtl/frame_deserializer_if.sv
// Bundles the tick-sampled serial input, read strobe and receive-status outputs of frame_deserializer.
// The master drives the serial line, tick and rd; the slave (the deserializer) returns q and status.
interface frame_deserializer_if #(
    parameter int N = 8
);
    logic         tick;
    logic         sin;
    logic         rd;
    logic [N-1:0] q;
    logic         full;
    logic         overrun;
    logic         frame_err;
    logic         busy;

    modport master (
        output tick, sin, rd,
        input  q, full, overrun, frame_err, busy
    );

    modport slave (
        input  tick, sin, rd,
        output q, full, overrun, frame_err, busy
    );
endinterface

// File: rtl/frame_deserializer.sv
// Tick-sampled start/N-data-LSB-first/stop receiver; q/full/frame_err update on the edge ending the stop tick.
// No backpressure: an unread word is overwritten and flagged by sticky overrun until rd acknowledges it.
module frame_deserializer #(
    parameter int N = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    frame_deserializer_if.slave     bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_STOP,
        S_WAITHI
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  word_q, word_d;
    logic          full_q, full_d;
    logic          ovr_q, ovr_d;
    logic          ferr_q, ferr_d;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            word_q  <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            word_q  <= word_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        word_d  = word_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        ferr_d  = 1'b0;

        // A read is applied first so a same-cycle good stop re-fills without flagging overrun.
        if (bus.rd && full_q) begin
            full_d = 1'b0;
            ovr_d  = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (bus.tick && !bus.sin) begin
                    state_d = S_DATA;
                    cnt_d   = '0;
                end
            end
            S_DATA: begin
                if (bus.tick) begin
                    shift_d = {bus.sin, shift_q[N-1:1]};
                    if (cnt_q == CW'(N - 1)) begin
                        state_d = S_STOP;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            S_STOP: begin
                if (bus.tick) begin
                    if (bus.sin) begin
                        word_d  = shift_q;
                        full_d  = 1'b1;
                        if (full_q && !bus.rd) begin
                            ovr_d = 1'b1;
                        end
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAITHI;
                    end
                end
            end
            S_WAITHI: begin
                // Hold here until the line returns high so a stuck-low line cannot look like a start bit.
                if (bus.tick && bus.sin) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.q         = word_q;
    assign bus.full      = full_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_frame_deserializer.sv
// Directed frames for frame_deserializer (N=8) with a queue-based scoreboard.
// A monitor pops one expectation per frame_err pulse or busy falling edge.
module tb_frame_deserializer;
    logic clk;
    logic reset;

    frame_deserializer_if #(.N(8)) bus();

    frame_deserializer #(.N(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       ferr;
        logic [7:0] q;
        logic       full;
        logic       ovr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ferr_seen = 0;

    logic [7:0] m_q;
    logic       m_full;
    logic       m_ovr;

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: one expectation per frame_err pulse or busy falling edge.
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        if (bus.frame_err === 1'b1 || (prev_busy === 1'b1 && bus.busy === 1'b0)) begin
            if (bus.frame_err === 1'b1) ferr_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event: frame_err=%b busy=%b with empty scoreboard at %0t",
                         bus.frame_err, bus.busy, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("mon_frame_err", {7'd0, bus.frame_err}, {7'd0, e.ferr});
                chk("mon_q",         bus.q,                  e.q);
                chk("mon_full",      {7'd0, bus.full},       {7'd0, e.full});
                chk("mon_overrun",   {7'd0, bus.overrun},    {7'd0, e.ovr});
            end
        end
        prev_busy = bus.busy;
    end

    task automatic clk_wait();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic ferr);
        exp_t e;
        e.ferr = ferr;
        e.q    = m_q;
        e.full = m_full;
        e.ovr  = m_ovr;
        exp_q.push_back(e);
    endtask

    // Three non-tick cycles (optionally with the inverted level on sin), then one tick cycle.
    task automatic send_bit(input logic b, input logic rd_t, input logic glitch);
        bus.sin  = glitch ? ~b : b;
        bus.tick = 1'b0;
        repeat (3) clk_wait();
        bus.sin  = b;
        bus.tick = 1'b1;
        bus.rd   = rd_t;
        clk_wait();
        bus.tick = 1'b0;
        bus.rd   = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input logic rd_stop,
                              input logic glitch);
        send_bit(1'b0, 1'b0, 1'b0);
        chk("busy_after_start", {7'd0, bus.busy}, 8'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i], 1'b0, glitch);
        if (stop) begin
            if (rd_stop) m_ovr = 1'b0;
            else if (m_full) m_ovr = 1'b1;
            m_q    = d;
            m_full = 1'b1;
            push(1'b0);
        end else begin
            push(1'b1);
        end
        send_bit(stop, rd_stop, 1'b0);
    endtask

    task automatic do_read();
        bus.rd = 1'b1;
        clk_wait();
        bus.rd = 1'b0;
        if (m_full) begin
            m_full = 1'b0;
            m_ovr  = 1'b0;
        end
    endtask

    initial begin
        bus.tick = 1'b0;
        bus.sin  = 1'b1;
        bus.rd   = 1'b0;
        reset    = 1'b0;
        m_q      = 8'h00;
        m_full   = 1'b0;
        m_ovr    = 1'b0;
        repeat (3) clk_wait();
        chk("rst_q",         bus.q,                    8'h00);
        chk("rst_full",      {7'd0, bus.full},         8'd0);
        chk("rst_overrun",   {7'd0, bus.overrun},      8'd0);
        chk("rst_frame_err", {7'd0, bus.frame_err},    8'd0);
        chk("rst_busy",      {7'd0, bus.busy},         8'd0);
        reset = 1'b1;
        repeat (2) clk_wait();

        // Basic frame.
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        chk("a5_q",       bus.q,               8'hA5);
        chk("a5_full",    {7'd0, bus.full},    8'd1);
        chk("a5_overrun", {7'd0, bus.overrun}, 8'd0);
        chk("a5_busy",    {7'd0, bus.busy},    8'd0);
        do_read();
        chk("a5_read_full", {7'd0, bus.full}, 8'd0);

        // Bad stop bit, line held low for three ticks, then released.
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 1'b0, 1'b0);
        chk("waithi_busy",      {7'd0, bus.busy},      8'd1);
        chk("waithi_frame_err", {7'd0, bus.frame_err}, 8'd0);
        push(1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        chk("recover_busy", {7'd0, bus.busy}, 8'd0);
        chk("badstop_q",    bus.q,            8'hA5);
        chk("badstop_full", {7'd0, bus.full}, 8'd0);

        // Overwrite of an unread word.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0);
        chk("ovr_q",       bus.q,               8'h22);
        chk("ovr_full",    {7'd0, bus.full},    8'd1);
        chk("ovr_overrun", {7'd0, bus.overrun}, 8'd1);
        do_read();
        chk("ovr_rd_full",    {7'd0, bus.full},    8'd0);
        chk("ovr_rd_overrun", {7'd0, bus.overrun}, 8'd0);

        // Read in the same cycle as the second stop tick.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1, 1'b0);
        chk("rdstop_q",       bus.q,               8'h22);
        chk("rdstop_full",    {7'd0, bus.full},    8'd1);
        chk("rdstop_overrun", {7'd0, bus.overrun}, 8'd0);
        do_read();

        // Reset in the middle of frame 0xFF, then a clean frame.
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0);
        reset  = 1'b0;
        m_q    = 8'h00;
        m_full = 1'b0;
        m_ovr  = 1'b0;
        push(1'b0);
        clk_wait();
        reset = 1'b1;
        chk("abort_q", bus.q, 8'h00);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        chk("post_rst_q",    bus.q,            8'h5A);
        chk("post_rst_full", {7'd0, bus.full}, 8'd1);
        do_read();

        // sin toggled between ticks must not matter.
        send_frame(8'h96, 1'b1, 1'b0, 1'b1);
        chk("glitch_q", bus.q, 8'h96);

        repeat (4) clk_wait();
        chk("scoreboard_drained", 8'(exp_q.size()), 8'd0);
        chk("frame_err_pulses",   8'(ferr_seen),    8'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
